// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - opcode/funct constants, ALUOp codes and FSM encodings for mips_mc_ctrl
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ADD is code 0 so that idle/reset ALUOp and the fetch increment share one value
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11,
    ALU_ADDU = 5'd12,
    ALU_SUBU = 5'd13
  } aluop_e;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXR  = 4'd2,
    S_EXI  = 4'd3,
    S_WBR  = 4'd4,
    S_WBI  = 4'd5,
    S_MA   = 4'd6,
    S_MRD  = 4'd7,
    S_MWB  = 4'd8,
    S_MWR  = 4'd9,
    S_BR   = 4'd10,
    S_JMP  = 4'd11,
    S_TRAP = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } srcb_e;

  function automatic logic op_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// rtl/mips_mc_aludec.sv - combinational Op/Funct to ALUOp decode with legal flag
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRL:  alu_op = ALU_SRL;
        FN_SRA:  alu_op = ALU_SRA;
        FN_ADD:  alu_op = ALU_ADD;
        FN_ADDU: alu_op = ALU_ADDU;
        FN_SUB:  alu_op = ALU_SUB;
        FN_SUBU: alu_op = ALU_SUBU;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLTU: alu_op = ALU_SLTU;
        default: legal  = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI:        alu_op = ALU_ADD;
        OP_ADDIU:       alu_op = ALU_ADDU;
        OP_SLTI:        alu_op = ALU_SLT;
        OP_ANDI:        alu_op = ALU_AND;
        OP_ORI:         alu_op = ALU_OR;
        OP_LUI:         alu_op = ALU_LUI;
        OP_LW, OP_SW:   alu_op = ALU_ADD;
        OP_BEQ, OP_BNE: alu_op = ALU_SUB;
        default:        legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM with memory handshake and timeout trap
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               ALUZero,
  input  logic               MemReady,
  output logic               MemReq,
  output logic               MemWE,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               Mem2Reg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               BusErr,
  output logic [STATE_W-1:0] State,
  output logic [31:0]        CycleCount,
  output logic [31:0]        InstrRetired
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             to_expire;

  logic [4:0] dec_aluop;
  logic       dec_legal;

  logic       c_mem_req, c_mem_we, c_iord, c_ir_write, c_pc_write;
  logic [1:0] c_pc_src, c_srcb;
  logic       c_reg_write, c_reg_dst, c_mem2reg, c_srca, c_ext, c_bus_err;
  logic [4:0] c_alu_op;

  mips_mc_aludec u_aludec (
    .op     (Op),
    .funct  (Funct),
    .alu_op (dec_aluop),
    .legal  (dec_legal)
  );

  // The access being waited on is on its last allowed cycle; MemReady now still completes it
  assign to_expire = (MEM_TIMEOUT != 0) && (wait_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    c_mem_req   = 1'b0;
    c_mem_we    = 1'b0;
    c_iord      = 1'b0;
    c_ir_write  = 1'b0;
    c_pc_write  = 1'b0;
    c_pc_src    = PCSRC_ALU;
    c_reg_write = 1'b0;
    c_reg_dst   = 1'b0;
    c_mem2reg   = 1'b0;
    c_srca      = 1'b0;
    c_srcb      = SRCB_RT;
    c_ext       = 1'b0;
    c_alu_op    = ALU_ADD;
    c_bus_err   = 1'b0;

    case (state_q)
      S_IF: begin
        c_mem_req = 1'b1;
        c_srcb    = SRCB_FOUR;
        if (MemReady) begin
          c_ir_write = 1'b1;
          c_pc_write = 1'b1;
          state_d    = S_ID;
        end else if (to_expire) begin
          state_d = S_TRAP;
        end
      end
      S_ID: begin
        c_srcb = SRCB_IMM_SH2;
        c_ext  = 1'b1;
        case (Op)
          OP_RTYPE:       state_d = S_EXR;
          OP_LW, OP_SW:   state_d = S_MA;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:           state_d = S_JMP;
          OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXI;
          default:        state_d = S_TRAP;
        endcase
      end
      S_EXR: begin
        c_srca   = 1'b1;
        c_srcb   = SRCB_RT;
        c_alu_op = dec_aluop;
        state_d  = dec_legal ? S_WBR : S_TRAP;
      end
      S_EXI: begin
        c_srca   = 1'b1;
        c_srcb   = SRCB_IMM;
        c_ext    = !op_zero_ext(Op);
        c_alu_op = dec_aluop;
        state_d  = S_WBI;
      end
      S_WBR: begin
        c_reg_write = 1'b1;
        c_reg_dst   = 1'b1;
        state_d     = S_IF;
      end
      S_WBI: begin
        c_reg_write = 1'b1;
        state_d     = S_IF;
      end
      S_MA: begin
        c_srca  = 1'b1;
        c_srcb  = SRCB_IMM;
        c_ext   = 1'b1;
        state_d = (Op == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        c_mem_req = 1'b1;
        c_iord    = 1'b1;
        if (MemReady)       state_d = S_MWB;
        else if (to_expire) state_d = S_TRAP;
      end
      S_MWB: begin
        c_reg_write = 1'b1;
        c_mem2reg   = 1'b1;
        state_d     = S_IF;
      end
      S_MWR: begin
        c_mem_req = 1'b1;
        c_iord    = 1'b1;
        c_mem_we  = 1'b1;
        if (MemReady)       state_d = S_IF;
        else if (to_expire) state_d = S_TRAP;
      end
      S_BR: begin
        c_srca     = 1'b1;
        c_srcb     = SRCB_RT;
        c_alu_op   = ALU_SUB;
        c_pc_src   = PCSRC_ALUOUT;
        c_pc_write = (Op == OP_BEQ) ? ALUZero : !ALUZero;
        state_d    = S_IF;
      end
      S_JMP: begin
        c_pc_write = 1'b1;
        c_pc_src   = PCSRC_JUMP;
        state_d    = S_IF;
      end
      S_TRAP: begin
        c_bus_err = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    wait_d = '0;
    if ((state_d == state_q) && c_mem_req && !MemReady) wait_d = wait_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are forced low while RST is held so an access in flight is dropped at once
  assign MemReq   = RST & c_mem_req;
  assign MemWE    = RST & c_mem_we;
  assign IorD     = RST & c_iord;
  assign IRWrite  = RST & c_ir_write;
  assign PCWrite  = RST & c_pc_write;
  assign PCSrc    = RST ? c_pc_src : 2'b00;
  assign RegWrite = RST & c_reg_write;
  assign RegDst   = RST & c_reg_dst;
  assign Mem2Reg  = RST & c_mem2reg;
  assign ALUSrcA  = RST & c_srca;
  assign ALUSrcB  = RST ? c_srcb : 2'b00;
  assign ExtOp    = RST & c_ext;
  assign ALUOp    = RST ? ALUOP_W'(c_alu_op) : '0;
  assign BusErr   = RST & c_bus_err;
  assign State    = STATE_W'(state_q);

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;
  logic        retire;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_WBR, S_WBI, S_MWB, S_MWR, S_BR, S_JMP: retire = (state_d == S_IF);
      default:                                 retire = 1'b0;
    endcase
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (state_q != S_TRAP) begin
      cyc_d = cyc_q + 32'd1;
      if (retire) ret_d = ret_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign CycleCount   = cyc_q;
  assign InstrRetired = ret_q;
`else
  assign CycleCount   = '0;
  assign InstrRetired = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;
  import mips_mc_pkg::*;

`ifdef MC_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [5:0]  Op = 6'h00;
  logic [5:0]  Funct = 6'h00;
  logic        ALUZero = 1'b0;
  logic        MemReady = 1'b0;
  logic        MemReq, MemWE, IorD, IRWrite, PCWrite, RegWrite, RegDst, Mem2Reg;
  logic        ALUSrcA, ExtOp, BusErr;
  logic [1:0]  PCSrc, ALUSrcB;
  logic [4:0]  ALUOp;
  logic [3:0]  State;
  logic [31:0] CycleCount, InstrRetired;

  int checks = 0;
  int errors = 0;

  mips_mc_ctrl #(.ALUOP_W(5), .MEM_TIMEOUT(4), .STATE_W(4)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .ALUZero(ALUZero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWE(MemWE), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp), .BusErr(BusErr),
    .State(State), .CycleCount(CycleCount), .InstrRetired(InstrRetired)
  );

  always #5 CLK = ~CLK;

  logic [23:0] outs;
  logic [15:0] ifv;
  logic [11:0] idv;
  logic [8:0]  exv, lastv;
  assign outs  = {MemReq, MemWE, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, Mem2Reg,
                  ALUSrcA, ALUSrcB, ExtOp, ALUOp, BusErr, State};
  assign ifv   = {MemReq, IorD, ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite, PCSrc, RegWrite, MemWE};
  assign idv   = {ALUSrcA, ALUSrcB, ExtOp, ALUOp, MemReq, PCWrite, RegWrite};
  assign exv   = {ALUSrcA, ALUSrcB, ExtOp, ALUOp};
  assign lastv = {MemReq, MemWE, IorD, RegWrite, RegDst, Mem2Reg, PCWrite, PCSrc};

  localparam logic [15:0] IF_EXP   = {1'b1, 1'b0, 1'b0, 2'd1, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
  localparam logic [11:0] ID_EXP   = {1'b0, 2'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] TRAP_EXP = {19'd0, 1'b1, 4'd12};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;
    logic [19:0] seq;
    logic [8:0]  ex;
    logic [8:0]  last;
  } vec_t;

  vec_t vecs [19];
  vec_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] sq(input state_e a, input state_e b, input state_e c,
                                     input state_e d, input state_e e);
    return {a, b, c, d, e};
  endfunction

  function automatic logic [8:0] ex_v(input logic a, input logic [1:0] b, input logic e,
                                      input aluop_e op);
    return {a, b, e, op};
  endfunction

  function automatic logic [8:0] last_v(input logic rq, input logic we, input logic iord,
                                        input logic rw, input logic rd, input logic m2r,
                                        input logic pcw, input logic [1:0] pcs);
    return {rq, we, iord, rw, rd, m2r, pcw, pcs};
  endfunction

  task automatic do_reset();
    RST = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  // Runs one instruction from IF back to IF with zero wait states
  task automatic run_instr(input vec_t v, output int len, output logic [19:0] seq,
                           output logic [8:0] ex, output logic [8:0] last,
                           output logic [15:0] ifs, output logic [11:0] ids);
    Op = v.op; Funct = v.funct; ALUZero = v.zero; MemReady = 1'b1;
    len = 0; seq = '0; ex = '0; last = '0; ifs = '0; ids = '0;
    do begin
      @(negedge CLK);
      len++;
      if (len <= 5) seq = {seq[15:0], State};
      if (len == 1) ifs = ifv;
      if (len == 2) ids = idv;
      if (len == 3) ex = exv;
      last = lastv;
      @(posedge CLK);
      #1;
    end while (State != S_IF && len < 12);
    for (int k = len; k < 5; k++) seq = {seq[15:0], 4'h0};
  endtask

  task automatic run_lw(input int if_w, input int mrd_w);
    int n_req = 0;
    int n_irw = 0;
    int tot = if_w + mrd_w + 5;
    Op = OP_LW; Funct = 6'h00;
    for (int c = 1; c <= tot; c++) begin
      MemReady = !((c <= if_w) || (c >= if_w + 4 && c <= if_w + 3 + mrd_w));
      @(negedge CLK);
      if (MemReq && IorD) n_req++;
      if (IRWrite) n_irw++;
      if (c == tot) begin
        check($sformatf("lw%0d_%0d_mwb_state", if_w, mrd_w), 32'(State), 32'(S_MWB));
        check($sformatf("lw%0d_%0d_mem2reg", if_w, mrd_w), 32'(Mem2Reg), 32'd1);
      end
      @(posedge CLK);
      #1;
    end
    check($sformatf("lw%0d_%0d_mrd_req_cycles", if_w, mrd_w), 32'(n_req), 32'(mrd_w + 1));
    check($sformatf("lw%0d_%0d_irwrite_cycles", if_w, mrd_w), 32'(n_irw), 32'd1);
    check($sformatf("lw%0d_%0d_back_to_if", if_w, mrd_w), 32'(State), 32'(S_IF));
  endtask

  task automatic run_trap_seq(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input int n, input logic [19:0] exp_seq);
    logic [19:0] s = '0;
    do_reset();
    Op = op; Funct = fn; MemReady = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      s = {s[15:0], State};
      @(posedge CLK);
      #1;
    end
    check({name, "_seq"}, 32'(s), 32'(exp_seq));
    check({name, "_outs"}, 32'(outs), 32'(TRAP_EXP));
    check({name, "_len"}, 32'(n), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    logic [19:0] seq;
    logic [8:0]  ex, last;
    logic [15:0] ifs;
    logic [11:0] ids;
    vec_t        e;
    int          n_if, n_req;

    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, sq(S_IF, S_ID, S_EXR, S_WBR, S_IF), ex_v(1, 0, 0, ALU_ADD),  last_v(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, sq(S_IF, S_ID, S_EXR, S_WBR, S_IF), ex_v(1, 0, 0, ALU_SUB),  last_v(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[2]  = '{6'h00, 6'h24, 1'b0, 4, sq(S_IF, S_ID, S_EXR, S_WBR, S_IF), ex_v(1, 0, 0, ALU_AND),  last_v(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 4, sq(S_IF, S_ID, S_EXR, S_WBR, S_IF), ex_v(1, 0, 0, ALU_OR),   last_v(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 4, sq(S_IF, S_ID, S_EXR, S_WBR, S_IF), ex_v(1, 0, 0, ALU_SLT),  last_v(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[5]  = '{6'h00, 6'h00, 1'b0, 4, sq(S_IF, S_ID, S_EXR, S_WBR, S_IF), ex_v(1, 0, 0, ALU_SLL),  last_v(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[6]  = '{6'h08, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_EXI, S_WBI, S_IF), ex_v(1, 2, 1, ALU_ADD),  last_v(0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[7]  = '{6'h09, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_EXI, S_WBI, S_IF), ex_v(1, 2, 1, ALU_ADDU), last_v(0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[8]  = '{6'h0A, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_EXI, S_WBI, S_IF), ex_v(1, 2, 1, ALU_SLT),  last_v(0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[9]  = '{6'h0C, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_EXI, S_WBI, S_IF), ex_v(1, 2, 0, ALU_AND),  last_v(0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[10] = '{6'h0D, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_EXI, S_WBI, S_IF), ex_v(1, 2, 0, ALU_OR),   last_v(0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[11] = '{6'h0F, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_EXI, S_WBI, S_IF), ex_v(1, 2, 0, ALU_LUI),  last_v(0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[12] = '{6'h23, 6'h3F, 1'b0, 5, sq(S_IF, S_ID, S_MA, S_MRD, S_MWB), ex_v(1, 2, 1, ALU_ADD),  last_v(0, 0, 0, 1, 0, 1, 0, 0)};
    vecs[13] = '{6'h2B, 6'h3F, 1'b0, 4, sq(S_IF, S_ID, S_MA, S_MWR, S_IF),  ex_v(1, 2, 1, ALU_ADD),  last_v(1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[14] = '{6'h04, 6'h3F, 1'b1, 3, sq(S_IF, S_ID, S_BR, S_IF, S_IF),   ex_v(1, 0, 0, ALU_SUB),  last_v(0, 0, 0, 0, 0, 0, 1, 1)};
    vecs[15] = '{6'h05, 6'h3F, 1'b1, 3, sq(S_IF, S_ID, S_BR, S_IF, S_IF),   ex_v(1, 0, 0, ALU_SUB),  last_v(0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[16] = '{6'h04, 6'h3F, 1'b0, 3, sq(S_IF, S_ID, S_BR, S_IF, S_IF),   ex_v(1, 0, 0, ALU_SUB),  last_v(0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[17] = '{6'h05, 6'h3F, 1'b0, 3, sq(S_IF, S_ID, S_BR, S_IF, S_IF),   ex_v(1, 0, 0, ALU_SUB),  last_v(0, 0, 0, 0, 0, 0, 1, 1)};
    vecs[18] = '{6'h02, 6'h3F, 1'b0, 3, sq(S_IF, S_ID, S_JMP, S_IF, S_IF),  ex_v(0, 0, 0, ALU_ADD),  last_v(0, 0, 0, 0, 0, 0, 1, 2)};

    // Reset values while RST is held low
    MemReady = 1'b1;
    #3;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_cycles", CycleCount, 32'd0);
    check("reset_retired", InstrRetired, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Table of instructions at zero wait
    for (int i = 0; i < 19; i++) begin
      sb.push_back(vecs[i]);
      run_instr(vecs[i], len, seq, ex, last, ifs, ids);
      e = sb.pop_front();
      check($sformatf("v%0d_len", i), 32'(len), 32'(e.len));
      check($sformatf("v%0d_states", i), 32'(seq), 32'(e.seq));
      check($sformatf("v%0d_if", i), 32'(ifs), 32'(IF_EXP));
      check($sformatf("v%0d_id", i), 32'(ids), 32'(ID_EXP));
      check($sformatf("v%0d_exec", i), 32'(ex), 32'(e.ex));
      check($sformatf("v%0d_last", i), 32'(last), 32'(e.last));
    end

    // lw with wait states, including readiness on the final allowed wait cycle
    run_lw(0, 3);
    run_lw(3, 3);

    // Fetch stalls until timeout
    do_reset();
    Op = OP_RTYPE; Funct = FN_ADD; MemReady = 1'b0;
    n_if = 0; n_req = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (State == S_IF) n_if++;
      if (MemReq) n_req++;
      @(posedge CLK);
      #1;
    end
    check("timeout_if_cycles", 32'(n_if), 32'd4);
    check("timeout_req_cycles", 32'(n_req), 32'd4);
    check("timeout_trap_outs", 32'(outs), 32'(TRAP_EXP));
    check("timeout_cycles_frozen", CycleCount, 32'(PERF * 4));
    MemReady = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("trap_held_outs", 32'(outs), 32'(TRAP_EXP));
    check("trap_held_cycles", CycleCount, 32'(PERF * 4));
    check("trap_retired", InstrRetired, 32'd0);
    #1 RST = 1'b0;
    #1;
    check("trap_reset_outs", 32'(outs), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("post_trap_state", 32'(State), 32'(S_IF));
    check("post_trap_buserr", 32'(BusErr), 32'd0);
    @(posedge CLK);
    #1;

    // Illegal opcode and illegal funct
    run_trap_seq("bad_op", 6'h3F, 6'h20, 3, sq(S_IF, S_ID, S_TRAP, S_TRAP, S_TRAP));
    run_trap_seq("bad_funct", 6'h00, 6'h3F, 4, sq(S_IF, S_ID, S_EXR, S_TRAP, S_TRAP));

    // Performance counters over ten R-types
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[0], len, seq, ex, last, ifs, ids);
      check($sformatf("perf_r%0d_len", i), 32'(len), 32'd4);
    end
    check("perf_retired", InstrRetired, 32'(PERF * 10));
    check("perf_cycles", CycleCount, 32'(PERF * 40));

    // Reset asserted while a store is waiting in MWR
    Op = OP_SW; Funct = 6'h00;
    for (int c = 1; c <= 4; c++) begin
      MemReady = (c <= 3);
      @(negedge CLK);
      if (c == 4) begin
        check("mwr_state", 32'(State), 32'(S_MWR));
        check("mwr_req", 32'(MemReq), 32'd1);
      end
      if (c < 4) begin
        @(posedge CLK);
        #1;
      end
    end
    #1 RST = 1'b0;
    #1;
    check("mwr_reset_req", 32'(MemReq), 32'd0);
    check("mwr_reset_outs", 32'(outs), 32'd0);
    check("mwr_reset_cycles", CycleCount, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
